seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector. Successor to the fixed 1101 T-flip-flop detector.
- Pattern, active length and overlap mode are runtime-configurable.
- Input is a valid-qualified bit stream; output is a registered match pulse plus a saturating match counter.
- Sits between a serial receiver and status logic; one instance per channel.

Parameters:
- PAT_W, 4: maximum pattern length in bits (≥1).
- CNT_W, 8: width of match_count.
- RST_PAT, 4'b1101 (PAT_W bits): pattern loaded at reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_load  in  1  load cfg_pattern/cfg_len/cfg_overlap this cycle.
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  $clog2(PAT_W+1)  active pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- in_valid  in  1  in_bit is accepted this cycle.
- in_bit  in  1  serial data bit.
- count_clr  in  1  synchronous clear of match_count.
- match  out  1  one-cycle pulse, registered.
- match_count  out  CNT_W  saturating count of matches.
- armed  out  1  history holds at least len valid bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - history = 0, fill = 0, state = FILL.
  - match = 0, match_count = 0, armed = 0.
  - pattern = RST_PAT, len = PAT_W, overlap = 1.
- Config:
  - cfg_len of 0 or > PAT_W is clamped to PAT_W.
  - cfg_load clears history and fill and sets state = FILL. match_count is kept.
  - cfg_load has priority over in_valid in the same cycle: that input bit is dropped and match stays 0 next cycle.
- Datapath on each accepted bit (in_valid=1, cfg_load=0):
  - history <= {history[PAT_W-2:0], in_bit}.
  - fill saturates at len.
- Compare is combinational on the post-shift value: low len bits of the new history vs low len bits of pattern. Bits above len are ignored.
- State machine:
  - FILL: fill+1 < len after the shift → stay in FILL.
  - FILL → ARMED: the accepted bit brings fill to len. The compare is evaluated on that same bit.
  - ARMED, compare true:
    - match <= 1 on the next edge, so latency is 1 cycle after the completing bit's edge.
    - If overlap = 1: stay in ARMED, history kept.
    - If overlap = 0: history and fill cleared, go to FILL.
  - ARMED, compare false: stay in ARMED.
  - armed = (state == ARMED), registered.
- in_valid = 0: no shift, no state change, match <= 0. Gaps between bits are transparent.
- match_count:
  - +1 per match, saturating at all-ones with no wrap.
  - count_clr and a match in the same cycle → match_count = 1.
  - count_clr alone → 0.
- len = 1: every accepted bit equal to pattern[0] matches, in either mode.
- Reset asserted mid-stream: all state returns to reset values immediately, and match deasserts asynchronously.

Decomposition:
- Package seq_det_pkg holds:
  - state enum {ST_FILL, ST_ARMED}
  - DEFAULT_PAT constant
  - a len-clamp function
  - a masked-compare function (history, pattern, len)
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, clr, q) implements match_count.
- Everything else lives in the top module.

Test Plan:
- Defaults after reset, stream 1101110111011101 MSB first, contiguous valid → match pulses after bits 4, 8, 12, 16; match_count = 4.
- Pattern 1101, len 4, overlap=1, stream 1101101 → matches after bits 4 and 7, count = 2. Repeat with overlap=0 → single match after bit 4, count = 1.
- cfg_load pattern 3'b011, len 3, asserted together with in_valid → that bit is dropped, armed = 0. Then stream 0110011 → matches after accepted bits 3 and 7.
- Saturation with CNT_W = 2: five matches → count sequence 1, 2, 3, 3, 3. Then count_clr coinciding with a match → count = 1.
- Stream 1101 with in_valid toggled 1,0,1,0,... → exactly one match, one cycle after the 4th accepted bit. No match on idle cycles.
- Assert rst_n low while armed with 3 bits of 1101 in history → match = 0, count = 0, armed = 0 at once. After release, bit 1 alone gives no match; a full 1101 gives one match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types, defaults and helper functions for seq_detector_param
package seq_det_pkg;
   typedef enum logic {ST_FILL, ST_ARMED} state_t;
   localparam logic [3:0] DEFAULT_PAT = 4'b1101;
   function automatic int clamp_len(int l, int pw);
      return (l < 1 || l > pw) ? pw : l;
   endfunction
   // Only the low len bits take part; anything above is stale or unused history.
   function automatic logic masked_eq(logic [31:0] h, logic [31:0] p, int len);
      logic [31:0] mask;
      mask = (len >= 32) ? '1 : ((32'd1 << len) - 32'd1);
      return ((h ^ p) & mask) == '0;
   endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: config, serial stream and status bundle for one detector channel
interface seq_detector_param_if #(parameter int PAT_W = 4, parameter int CNT_W = 8);
   localparam int LW = $clog2(PAT_W + 1);
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LW-1:0]    cfg_len;
   logic             cfg_overlap;
   logic             in_valid;
   logic             in_bit;
   logic             count_clr;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic             armed;
   modport master (output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, count_clr,
                   input match, match_count, armed);
   modport slave  (input cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit, count_clr,
                   output match, match_count, armed);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that can absorb a same-cycle increment
module sat_counter #(parameter int W = 8) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else q <= clr ? W'(inc) : (inc && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial pattern detector with match pulse and saturating count
module seq_detector_param import seq_det_pkg::*; #(
   parameter int               PAT_W   = 4,
   parameter int               CNT_W   = 8,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEFAULT_PAT)
) (
   input logic                 clk,
   input logic                 rst_n,
   seq_detector_param_if.slave bus
);
   localparam int LW = $clog2(PAT_W + 1);
   logic [PAT_W-1:0] pattern, hist, hist_nx;
   logic [LW-1:0]    len, fill, fill_nx;
   logic             overlap, acc, hit, match_r;
   state_t           state;
   assign acc     = bus.in_valid & ~bus.cfg_load;
   assign hist_nx = PAT_W'({hist, bus.in_bit});
   assign fill_nx = (fill < len) ? fill + LW'(1) : fill;
   assign hit     = acc && fill_nx == len && masked_eq(32'(hist_nx), 32'(pattern), int'(len));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pattern <= RST_PAT;
         len     <= LW'(PAT_W);
         overlap <= 1'b1;
         hist    <= '0;
         fill    <= '0;
         state   <= ST_FILL;
         match_r <= 1'b0;
      end else if (bus.cfg_load) begin
         pattern <= bus.cfg_pattern;
         len     <= LW'(clamp_len(int'(bus.cfg_len), PAT_W));
         overlap <= bus.cfg_overlap;
         hist    <= '0;
         fill    <= '0;
         state   <= ST_FILL;
         match_r <= 1'b0;
      end else begin
         match_r <= hit;
         // A non-overlapping hit consumes its bits, so refilling starts from scratch.
         if (acc && hit && !overlap) begin
            hist  <= '0;
            fill  <= '0;
            state <= ST_FILL;
         end else if (acc) begin
            hist  <= hist_nx;
            fill  <= fill_nx;
            state <= (fill_nx == len) ? ST_ARMED : ST_FILL;
         end
      end
   end
   assign bus.match = match_r;
   assign bus.armed = (state == ST_ARMED);
   sat_counter #(.W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (hit),
      .clr  (bus.count_clr),
      .q    (bus.match_count)
   );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed checks of two detector instances against a queue-based model
module tb_seq_detector_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) a ();
   seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) b ();
   assign b.cfg_load    = a.cfg_load;
   assign b.cfg_pattern = a.cfg_pattern;
   assign b.cfg_len     = a.cfg_len;
   assign b.cfg_overlap = a.cfg_overlap;
   assign b.in_valid    = a.in_valid;
   assign b.in_bit      = a.in_bit;
   assign b.count_clr   = a.count_clr;
   seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
   seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   bit q[$];
   logic [3:0] m_pat;
   int m_len;
   bit m_ov;
   int exp_match, exp_c8, exp_c2;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      q.delete();
      m_pat = 4'b1101;
      m_len = 4;
      m_ov = 1'b1;
      exp_match = 0;
      exp_c8 = 0;
      exp_c2 = 0;
   endtask
   // Model: the bits received since the last clear; a match is the newest len bits equalling the pattern.
   task automatic model_update();
      bit hit = 1'b0;
      if (a.cfg_load) begin
         q.delete();
         m_pat = a.cfg_pattern;
         m_len = (a.cfg_len == 0 || a.cfg_len > 4) ? 4 : int'(a.cfg_len);
         m_ov = a.cfg_overlap;
      end else if (a.in_valid) begin
         q.push_back(a.in_bit);
         if (q.size() > 4) void'(q.pop_front());
         if (q.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++) if (q[q.size()-1-i] != m_pat[i]) hit = 1'b0;
         end
         if (hit && !m_ov) q.delete();
      end
      exp_match = int'(hit);
      exp_c8 = a.count_clr ? int'(hit) : (hit && exp_c8 < 255) ? exp_c8 + 1 : exp_c8;
      exp_c2 = a.count_clr ? int'(hit) : (hit && exp_c2 < 3) ? exp_c2 + 1 : exp_c2;
   endtask
   task automatic drv(input logic cl, input logic [3:0] cp, input logic [2:0] cln, input logic cov,
                      input logic v, input logic bt, input logic clr);
      a.cfg_load = cl;
      a.cfg_pattern = cp;
      a.cfg_len = cln;
      a.cfg_overlap = cov;
      a.in_valid = v;
      a.in_bit = bt;
      a.count_clr = clr;
   endtask
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      #1;
   endtask
   task automatic cfgt(input logic [3:0] p, input logic [2:0] l, input logic ov);
      drv(1'b1, p, l, ov, 1'b0, 1'b0, 1'b0);
      tick();
   endtask
   task automatic clr_cnt();
      drv(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask
   task automatic feed(input logic [31:0] bits, input int n, input logic [31:0] mask);
      for (int i = n - 1; i >= 0; i--) begin
         drv(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, bits[i], 1'b0);
         tick();
         chk("feed_match", 32'(a.match), 32'(mask[i]));
      end
   endtask
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("match_a", 32'(a.match), 32'(exp_match));
         chk("match_b", 32'(b.match), 32'(exp_match));
         chk("count_a", 32'(a.match_count), 32'(exp_c8));
         chk("count_b", 32'(b.match_count), 32'(exp_c2));
         chk("armed_a", 32'(a.armed), 32'(q.size() >= m_len));
         chk("armed_b", 32'(b.armed), 32'(q.size() >= m_len));
      end
   end
   initial begin
      int sat_exp[4] = '{2, 3, 3, 3};
      int r;
      drv(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      chk("rst_match", 32'(a.match), 0);
      chk("rst_count", 32'(a.match_count), 0);
      chk("rst_armed", 32'(a.armed), 0);
      feed(32'b1101110111011101, 16, 32'b0001000100010001);
      chk("default_count_a", 32'(a.match_count), 4);
      chk("default_count_b", 32'(b.match_count), 3);
      cfgt(4'b1101, 3'd4, 1'b1);
      clr_cnt();
      feed(32'b1101101, 7, 32'b0001001);
      chk("ovl_count", 32'(a.match_count), 2);
      cfgt(4'b1101, 3'd4, 1'b0);
      clr_cnt();
      feed(32'b1101101, 7, 32'b0001000);
      chk("novl_count", 32'(a.match_count), 1);
      drv(1'b1, 4'b0011, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk("cfg_drop_armed", 32'(a.armed), 0);
      chk("cfg_drop_match", 32'(a.match), 0);
      feed(32'b0110011, 7, 32'b0010001);
      chk("len3_count", 32'(a.match_count), 3);
      cfgt(4'b1101, 3'd4, 1'b1);
      clr_cnt();
      feed(32'b1101, 4, 32'b0001);
      chk("sat_1", 32'(b.match_count), 1);
      for (int k = 0; k < 4; k++) begin
         feed(32'b101, 3, 32'b001);
         chk("sat_seq", 32'(b.match_count), 32'(sat_exp[k]));
      end
      feed(32'b10, 2, 32'b00);
      drv(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      chk("clr_hit_match", 32'(a.match), 1);
      chk("clr_hit_cnt_a", 32'(a.match_count), 1);
      chk("clr_hit_cnt_b", 32'(b.match_count), 1);
      cfgt(4'b1101, 3'd4, 1'b1);
      clr_cnt();
      for (int k = 3; k >= 0; k--) begin
         drv(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, k != 1, 1'b0);
         tick();
         chk("gap_bit_match", 32'(a.match), 32'(k == 0));
         drv(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick();
         chk("gap_idle_match", 32'(a.match), 0);
      end
      chk("gap_count", 32'(a.match_count), 1);
      cfgt(4'b1101, 3'd4, 1'b1);
      feed(32'b1101101, 7, 32'b0001001);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_match", 32'(a.match), 0);
      chk("async_count", 32'(a.match_count), 0);
      chk("async_armed", 32'(a.armed), 0);
      tick();
      rst_n = 1'b1;
      feed(32'b1, 1, 32'b0);
      feed(32'b101, 3, 32'b001);
      chk("post_rst_count", 32'(a.match_count), 1);
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 199));
         if (r < 5) begin
            drv(1'b1, 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            tick();
         end else if (r < 6) begin
            rst_n = 1'b0;
            model_reset();
            tick();
            rst_n = 1'b1;
         end else begin
            drv(1'b0, 4'd0, 3'd0, 1'b0, r < 150, 1'($urandom), $urandom_range(0, 59) == 0);
            tick();
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
